// File: rtl/seq_pattern_det.sv
// Programmable serial bit-pattern detector (Mealy match, runtime pattern/length/overlap).
// Define PATDET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module seq_pattern_det #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [LEN_W-1:0]   fill,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  // Low len bits set; selects the active part of the pattern and history window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  state_t             state_r, state_nxt;
  logic [MAX_LEN-2:0] hist_r, hist_nxt;
  logic [MAX_LEN-1:0] pat_r, pat_nxt;
  logic [LEN_W-1:0]   len_r, len_nxt;
  logic               overlap_r, overlap_nxt;
  logic [LEN_W-1:0]   fill_r, fill_nxt;

  logic               accept_s;
  logic               cfg_load_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [MAX_LEN-1:0] window_s;
  logic               pat_hit_s;
  logic               last_s;
  logic               match_s;

  // Only MAX_LEN-1 history bits are ever compared; the newest bit comes from bit_in directly.
  assign accept_s    = bit_valid && !cfg_we && (state_r != S_UNCFG);
  assign cfg_load_s  = cfg_we && (cfg_len != '0);
  assign len_clamp_s = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  assign window_s    = {hist_r, bit_in};
  assign pat_hit_s   = ((window_s ^ pat_r) & len_mask(len_r)) == '0;
  assign last_s      = (fill_r == (len_r - LEN_W'(1)));
  assign match_s     = accept_s && ((state_r == S_ARMED) || last_s) && pat_hit_s;

  assign match = match_s;
  assign fill  = fill_r;
  assign armed = (state_r == S_ARMED);

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_UNCFG;
      hist_r    <= '0;
      pat_r     <= '0;
      len_r     <= LEN_W'(1);
      overlap_r <= 1'b0;
      fill_r    <= '0;
    end else begin
      state_r   <= state_nxt;
      hist_r    <= hist_nxt;
      pat_r     <= pat_nxt;
      len_r     <= len_nxt;
      overlap_r <= overlap_nxt;
      fill_r    <= fill_nxt;
    end
  end

  // Next-state logic: configuration load has priority over bit acceptance.
  always_comb begin
    state_nxt   = state_r;
    hist_nxt    = hist_r;
    pat_nxt     = pat_r;
    len_nxt     = len_r;
    overlap_nxt = overlap_r;
    fill_nxt    = fill_r;
    if (cfg_load_s) begin
      state_nxt   = S_FILL;
      hist_nxt    = '0;
      pat_nxt     = cfg_pattern & len_mask(len_clamp_s);
      len_nxt     = len_clamp_s;
      overlap_nxt = cfg_overlap;
      fill_nxt    = '0;
    end else if (accept_s) begin
      hist_nxt = window_s[MAX_LEN-2:0];
      if (match_s && !overlap_r) begin
        state_nxt = S_FILL;
        fill_nxt  = '0;
      end else if (state_r == S_FILL) begin
        if (last_s) begin
          state_nxt = S_ARMED;
          fill_nxt  = len_r;
        end else begin
          fill_nxt = fill_r + LEN_W'(1);
        end
      end else begin
        state_nxt = state_r;
      end
    end else begin
      state_nxt = state_r;
    end
  end

`ifdef PATDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter, cleared on every accepted configuration write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cfg_load_s) begin
      cnt_r <= '0;
    end else if (match_s && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed table-driven bench for seq_pattern_det; a second CNT_W=2 instance shares the
// stimulus so counter saturation can be observed.
module tb_seq_pattern_det;

`ifdef PATDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       bit_valid;
  logic       bit_in;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       match, match2;
  logic [3:0] fill, fill2;
  logic       armed, armed2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int tests_run = 0;
  int tests_failed = 0;

  seq_pattern_det #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match), .fill(fill), .armed(armed),
    .match_cnt(match_cnt)
  );

  seq_pattern_det #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .match(match2), .fill(fill2), .armed(armed2),
    .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       b;
    logic       m;
    logic [3:0] f;
    logic       a;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_row(input logic [7:0] p, input logic [3:0] l, input logic ov,
                         input logic v, input logic b,
                         input logic [3:0] f, input logic a, input logic [7:0] c);
    vec_t r;
    r = '{we: 1'b1, pat: p, len: l, ov: ov, v: v, b: b, m: 1'b0, f: f, a: a, c: c};
    tbl.push_back(r);
  endtask

  task automatic bit_row(input logic v, input logic b, input logic m,
                         input logic [3:0] f, input logic a, input logic [7:0] c);
    vec_t r;
    r = '{we: 1'b0, pat: 8'h00, len: 4'd0, ov: 1'b0, v: v, b: b, m: m, f: f, a: a, c: c};
    tbl.push_back(r);
  endtask

  task automatic drive(input logic we, input logic [7:0] p, input logic [3:0] l,
                       input logic ov, input logic v, input logic b);
    @(negedge clk);
    cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    bit_valid = v; bit_in = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; cfg_we = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset match", {31'd0, match}, 32'd0);
    chk("reset fill", {28'd0, fill}, 32'd0);
    chk("reset armed", {31'd0, armed}, 32'd0);
    chk("reset cnt", {24'd0, match_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unconfigured: a stream of valid ones is ignored.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("uncfg match %0d", i), {31'd0, match}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("uncfg fill %0d", i), {28'd0, fill}, 32'd0);
      chk($sformatf("uncfg armed %0d", i), {31'd0, armed}, 32'd0);
    end

    // Overlap, pattern 1011 (upper pattern bits set to prove they are ignored).
    cfg_row(8'hFB, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd0);
    bit_row(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 8'd2);
    // Non-overlap, same stream.
    cfg_row(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd0);
    bit_row(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1);
    bit_row(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 8'd1);
    bit_row(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 8'd1);
    bit_row(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd1);
    // len=1, pattern 1, invalid gaps carry bit_in=1.
    cfg_row(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1);
    bit_row(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd1);
    bit_row(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2);
    bit_row(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd2);
    bit_row(1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 8'd2);
    bit_row(1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 8'd2);
    bit_row(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd3);
    // Config write colliding with a valid bit that would otherwise complete a match.
    cfg_row(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd0);
    bit_row(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0);
    cfg_row(8'h0B, 4'd4, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 8'd0);
    bit_row(1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 8'd1);
    // Zero-length write is ignored; pattern 1011 keeps matching with overlap.
    cfg_row(8'h01, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 8'd1);
    bit_row(1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 8'd2);
    // Length 15 clamps to 8: eight ones give one non-overlap match.
    cfg_row(8'hFF, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    for (int i = 1; i <= 7; i++) bit_row(1'b1, 1'b1, 1'b0, 4'(i), 1'b0, 8'd0);
    bit_row(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ov, tbl[i].v, tbl[i].b);
      chk($sformatf("row%0d match", i), {31'd0, match}, {31'd0, tbl[i].m});
      @(posedge clk); #1;
      chk($sformatf("row%0d fill", i), {28'd0, fill}, {28'd0, tbl[i].f});
      chk($sformatf("row%0d armed", i), {31'd0, armed}, {31'd0, tbl[i].a});
      chk($sformatf("row%0d cnt", i), {24'd0, match_cnt}, CNT_EN ? {24'd0, tbl[i].c} : 32'd0);
    end

    // Counter saturation on the 2-bit instance, then reset mid-stream over a config write.
    drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("sat match %0d", k), {31'd0, match2}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat cnt %0d", k), {30'd0, match_cnt2},
          CNT_EN ? ((k > 3) ? 32'd3 : 32'(k)) : 32'd0);
      chk($sformatf("sat armed %0d", k), {31'd0, armed2}, 32'd1);
      chk($sformatf("sat fill %0d", k), {28'd0, fill2}, 32'd1);
    end
    drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst armed", {31'd0, armed2}, 32'd0);
    chk("rst fill", {28'd0, fill2}, 32'd0);
    chk("rst cnt", {30'd0, match_cnt2}, 32'd0);
    chk("rst cnt8", {24'd0, match_cnt}, 32'd0);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    #1;
    chk("post-rst match", {31'd0, match2}, 32'd0);
    @(posedge clk); #1;
    chk("post-rst armed", {31'd0, armed2}, 32'd0);
    chk("post-rst fill", {28'd0, fill2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
